// File: rtl/clk_div_sched.sv
// Run-time divided-clock generator: clk_out/tick from clk_in with handshake-programmed ratio.
// Optional CLK_DIV_SYNC_RUN_EN puts a 2-flop synchronizer on run.
module clk_div_sched #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic             cfg_err
);

  // state | meaning
  // IDLE  | no output clock, cnt held at 0, configs apply directly
  // RUN   | producing periods while run is high
  // STOP  | run dropped mid-period; finishing the current period
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] cur_div_nxt;
  logic [DIV_W-1:0] pend_div, pend_div_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             clk_nxt, tick_nxt, err_nxt;
  logic             boundary, accept, run_q;

`ifdef CLK_DIV_SYNC_RUN_EN
  logic [1:0] run_sync;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) run_sync <= 2'b00;
    else       run_sync <= {run_sync[0], run};
  end

  assign run_q = run_sync[1];
`else
  assign run_q = run;
`endif

  assign cfg_ready = !pend_vld;
  assign busy      = (state != IDLE);
  assign boundary  = (state != IDLE) && (cnt == cur_div - 1'b1);
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_div_nxt  = cur_div;
    pend_vld_nxt = pend_vld;
    pend_div_nxt = pend_div;
    err_nxt      = 1'b0;

    // RUN and STOP only differ in which state run=0 leads to; both keep counting
    if (state == IDLE) begin
      cnt_nxt = '0;
      if (run_q) state_nxt = RUN;
    end else if (boundary) begin
      cnt_nxt   = '0;
      state_nxt = run_q ? RUN : IDLE;
    end else begin
      cnt_nxt   = cnt + 1'b1;
      state_nxt = run_q ? RUN : STOP;
    end

    // a pending ratio lands only where no period is in progress
    if (pend_vld && ((state == IDLE) || boundary)) begin
      cur_div_nxt  = pend_div;
      pend_vld_nxt = 1'b0;
    end

    if (accept) begin
      if (cfg_div < DIV_MIN) begin
        err_nxt = 1'b1;
      end else if (state == IDLE) begin
        cur_div_nxt = cfg_div;
      end else begin
        pend_vld_nxt = 1'b1;
        pend_div_nxt = cfg_div;
      end
    end

    // outputs registered from next-state so they match the state they appear with
    clk_nxt  = (state_nxt != IDLE) && (cnt_nxt < (cur_div_nxt >> 1));
    tick_nxt = (state_nxt != IDLE) && (cnt_nxt == '0);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= DIV_RST;
      pend_vld <= 1'b0;
      pend_div <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_div  <= cur_div_nxt;
      pend_vld <= pend_vld_nxt;
      pend_div <= pend_div_nxt;
      clk_out  <= clk_nxt;
      tick     <= tick_nxt;
      cfg_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed vector table, async reset sequence, random run vs period model.
module tb_clk_div_sched;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             run;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [DIV_W-1:0] cur_div;
  logic             cfg_err;

  clk_div_sched #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div),
    .cfg_err   (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit r; bit v; int d;
    bit e_clk; bit e_tick; bit e_busy; int e_cur; bit e_rdy; bit e_err;
  } vec_t;
  vec_t vecs[$];

  // period-level reference: active flag, position in period, ratio, one pending slot
  bit m_busy, m_pend, m_err;
  int m_pos, m_n, m_pend_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit c, input bit t, input bit b,
                           input int cur, input bit rdy, input bit e);
    check({tag, ".clk_out"},   32'(clk_out),   32'(c));
    check({tag, ".tick"},      32'(tick),      32'(t));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".cur_div"},   32'(cur_div),   32'(cur));
    check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(rdy));
    check({tag, ".cfg_err"},   32'(cfg_err),   32'(e));
  endtask

  function automatic void add(input bit r, input bit v, input int d, input bit c, input bit t,
                              input bit b, input int cur, input bit rdy, input bit e);
    vec_t x;
    x.r = r; x.v = v; x.d = d;
    x.e_clk = c; x.e_tick = t; x.e_busy = b; x.e_cur = cur; x.e_rdy = rdy; x.e_err = e;
    vecs.push_back(x);
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_pos = 0; m_n = DEFAULT_DIV; m_pend = 0; m_pend_n = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit r, input bit v, input int d);
    bit acc, was_busy, done;
    acc      = v && !m_pend;
    was_busy = m_busy;
    done     = m_busy && (m_pos == m_n - 1);
    if (!m_busy || done) begin
      if (m_pend) begin
        m_n    = m_pend_n;
        m_pend = 0;
      end
      m_pos  = 0;
      m_busy = r;
    end else begin
      m_pos++;
    end
    m_err = acc && (d < 2);
    if (acc && d >= 2) begin
      if (!was_busy) m_n = d;
      else begin
        m_pend   = 1;
        m_pend_n = d;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    do_reset();
    check_all("reset", 0, 0, 0, DEFAULT_DIV, 1, 0);

    //  run v  d   clk tick busy cur rdy err
    add(0, 1, 1,   0, 0, 0, 2, 1, 1);
    add(0, 1, 0,   0, 0, 0, 2, 1, 1);
    add(0, 0, 0,   0, 0, 0, 2, 1, 0);
    add(0, 1, 5,   0, 0, 0, 5, 1, 0);
    add(1, 0, 0,   1, 1, 1, 5, 1, 0);
    add(1, 0, 0,   1, 0, 1, 5, 1, 0);
    add(1, 0, 0,   0, 0, 1, 5, 1, 0);
    add(1, 0, 0,   0, 0, 1, 5, 1, 0);
    add(1, 0, 0,   0, 0, 1, 5, 1, 0);
    add(1, 0, 0,   1, 1, 1, 5, 1, 0);
    add(1, 1, 4,   1, 0, 1, 5, 0, 0);
    add(1, 0, 0,   0, 0, 1, 5, 0, 0);
    add(1, 0, 0,   0, 0, 1, 5, 0, 0);
    add(1, 0, 0,   0, 0, 1, 5, 0, 0);
    add(1, 0, 0,   1, 1, 1, 4, 1, 0);
    add(1, 0, 0,   1, 0, 1, 4, 1, 0);
    add(1, 1, 3,   0, 0, 1, 4, 0, 0);
    add(1, 0, 0,   0, 0, 1, 4, 0, 0);
    add(1, 0, 0,   1, 1, 1, 3, 1, 0);
    add(1, 0, 0,   0, 0, 1, 3, 1, 0);
    add(1, 0, 0,   0, 0, 1, 3, 1, 0);
    add(1, 0, 0,   1, 1, 1, 3, 1, 0);
    add(1, 1, 6,   0, 0, 1, 3, 0, 0);
    add(1, 0, 0,   0, 0, 1, 3, 0, 0);
    add(1, 0, 0,   1, 1, 1, 6, 1, 0);
    add(1, 0, 0,   1, 0, 1, 6, 1, 0);
    add(1, 0, 0,   1, 0, 1, 6, 1, 0);
    add(0, 0, 0,   0, 0, 1, 6, 1, 0);
    add(0, 0, 0,   0, 0, 1, 6, 1, 0);
    add(0, 0, 0,   0, 0, 1, 6, 1, 0);
    add(0, 0, 0,   0, 0, 0, 6, 1, 0);
    add(0, 0, 0,   0, 0, 0, 6, 1, 0);
    add(1, 0, 0,   1, 1, 1, 6, 1, 0);
    add(1, 0, 0,   1, 0, 1, 6, 1, 0);
    add(1, 0, 0,   1, 0, 1, 6, 1, 0);
    add(0, 0, 0,   0, 0, 1, 6, 1, 0);
    add(0, 0, 0,   0, 0, 1, 6, 1, 0);
    add(1, 0, 0,   0, 0, 1, 6, 1, 0);
    add(1, 0, 0,   1, 1, 1, 6, 1, 0);
    add(1, 0, 0,   1, 0, 1, 6, 1, 0);
    add(1, 0, 0,   1, 0, 1, 6, 1, 0);
    add(1, 0, 0,   0, 0, 1, 6, 1, 0);
    add(1, 0, 0,   0, 0, 1, 6, 1, 0);
    add(1, 0, 0,   0, 0, 1, 6, 1, 0);
    add(1, 1, 2,   1, 1, 1, 6, 0, 0);
    add(1, 0, 0,   1, 0, 1, 6, 0, 0);
    add(1, 0, 0,   1, 0, 1, 6, 0, 0);
    add(1, 0, 0,   0, 0, 1, 6, 0, 0);
    add(1, 0, 0,   0, 0, 1, 6, 0, 0);
    add(1, 0, 0,   0, 0, 1, 6, 0, 0);
    add(1, 0, 0,   1, 1, 1, 2, 1, 0);
    add(1, 0, 0,   0, 0, 1, 2, 1, 0);
    add(1, 0, 0,   1, 1, 1, 2, 1, 0);
    add(1, 1, 3,   0, 0, 1, 2, 0, 0);
    add(0, 0, 0,   0, 0, 0, 3, 1, 0);
    add(0, 0, 0,   0, 0, 0, 3, 1, 0);

    foreach (vecs[i]) begin
      run = vecs[i].r; cfg_valid = vecs[i].v; cfg_div = DIV_W'(vecs[i].d);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_clk, vecs[i].e_tick, vecs[i].e_busy,
                vecs[i].e_cur, vecs[i].e_rdy, vecs[i].e_err);
    end

    // async reset during the high phase with a config pending
    run = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd4;
    step();
    check_all("rst_pre0", 1, 1, 1, 4, 1, 0);
    cfg_valid = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    check_all("rst_pre1", 1, 0, 1, 4, 0, 0);
    @(posedge clk_in);
    #2 reset = 1'b1;
    #1 check_all("rst_async", 0, 0, 0, DEFAULT_DIV, 1, 0);
    run = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    step();
    check_all("rst_idle", 0, 0, 0, DEFAULT_DIV, 1, 0);
    run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_all($sformatf("div2_%0d", k), (k % 2) == 0, (k % 2) == 0, 1, DEFAULT_DIV, 1, 0);
    end

    do_reset();
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div   = DIV_W'($urandom_range(0, 9));
      @(posedge clk_in);
      model_step(run, cfg_valid, int'(cfg_div));
      @(negedge clk_in);
      check_all("rand", m_busy && (m_pos < m_n / 2), m_busy && (m_pos == 0), m_busy,
                m_n, !m_pend, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Run-time controller for the team's flop-based clock dividers. It generates a divided clock and a matching one-cycle tick from clk_in. The divide ratio is reprogrammed through a valid/ready config handshake. Start/stop and ratio changes take effect only at period boundaries, so clk_out never shows a runt pulse. It sits between the control/register logic and the blocks clocked or enabled by the divided clock.

Parameters:
DIV_W, 8, width of divide-ratio fields
DEFAULT_DIV, 2, ratio loaded at reset; must be >= 2 and < 2**DIV_W

Ports:
clk_in  input  1  single clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
run  input  1  level request to produce clk_out
cfg_valid  input  1  config request valid
cfg_div  input  DIV_W  requested divide ratio N
cfg_ready  output  1  controller can accept a config
clk_out  output  1  divided clock, driven directly from a flop
tick  output  1  one-cycle pulse coincident with first high cycle of each clk_out period
busy  output  1  high when state != IDLE
cur_div  output  DIV_W  ratio currently in force
cfg_err  output  1  one-cycle pulse: rejected config

Behaviour:
- Reset, asserted at any time including mid-period, forces all outputs immediately:
  - clk_out=0, tick=0, busy=0, cfg_err=0
  - cur_div=DEFAULT_DIV, cfg_ready=1
  - state=IDLE, cnt=0, pending config cleared
- State machine: IDLE, RUN, STOP. Period counter cnt runs 0..cur_div-1.
- clk_out and tick are flops. Their value in a cycle equals (state!=IDLE && cnt < cur_div>>1) and (state!=IDLE && cnt==0), evaluated on that cycle's registered state.
  - High phase is floor(N/2) cycles; low phase is ceil(N/2).
  - N=2 gives exactly clk_in/2 at 50% duty. N=5 gives 2 high, 3 low.
- IDLE: cnt held at 0, clk_out=0.
  - run=1 sampled -> RUN next cycle with cnt=0, so clk_out=1 and tick=1 one cycle after run is sampled.
- RUN: cnt increments each cycle; wraps to 0 after cur_div-1 (the boundary).
  - run=0 sampled at the boundary cycle -> IDLE next cycle.
  - run=0 sampled at any other cycle -> STOP.
- STOP: counting continues.
  - run=1 sampled -> RUN with no break in clk_out.
  - Boundary reached with run still 0 -> IDLE. The current period always completes.
- Config handshake: a transfer occurs on cfg_valid && cfg_ready. cfg_ready = !pending, held in a one-entry pending register.
  - cfg_div < 2: config discarded; cfg_err=1 next cycle; cfg_ready stays 1; cur_div unchanged.
  - Valid config in IDLE: cur_div updates the next cycle with no pending stage. If run=1 in the same cycle, the first period uses the new ratio.
  - Valid config in RUN/STOP: stored as pending; cfg_ready=0 from the next cycle.
    - At the next boundary cnt wraps to 0 with cur_div=pending value. Pending clears, and cfg_ready returns to 1 the following cycle.
    - A transfer in the boundary cycle itself is applied at the following boundary, not the current one.
  - Pending config at a boundary that goes to IDLE is applied on entry to IDLE.
- cur_div never changes mid-period while busy.

Optional Feature:
Macro CLK_DIV_SYNC_RUN_EN.
- Defined: run passes through a 2-flop synchronizer, reset to 0 by reset, before the FSM. All run-related latencies grow by 2 cycles (IDLE->first clk_out high = 3 cycles).
- Undefined: run is sampled directly, with latencies as above.

Test Plan:
- Reset, then run=1 with DEFAULT_DIV=2 -> clk_out=1 one cycle later, then toggles every cycle; tick on every clk_out high cycle; busy=1.
- In IDLE, cfg_div=5 accepted, then run=1 -> cur_div=5; clk_out pattern 1,1,0,0,0 repeating; tick every 5 cycles.
- Running N=4, cfg_div=3 accepted at cnt=1 -> cfg_ready=0; remainder of period stays N=4; next period is 1,0,0; cur_div changes at wrap; cfg_ready=1 one cycle after.
- Running N=6, run dropped at cnt=2 -> STOP; period completes (cnt 3..5); then IDLE, clk_out=0, busy=0. Repeat with run re-raised at cnt=4 -> no gap in clk_out.
- cfg_div=1 and cfg_div=0 -> cfg_err pulse each; cur_div unchanged; cfg_ready stays 1.
- reset asserted mid-high-phase with pending config -> clk_out, tick, busy drop asynchronously; cur_div=DEFAULT_DIV; cfg_ready=1; pending discarded after release.
